// File: rtl/spi_pkg.sv
// Shared SPI datapath definitions: bit-counter FSM states and the default
// counter and frame-tally widths.
package spi_pkg;

  // Bit-counter control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default counter width; the longest frame is 2**CNT_W-1 bits.
  localparam int SPI_CNT_W_DEF = 4;

  // Default width of the completed-frame tally.
  localparam int SPI_FRM_W_DEF = 8;

endpackage : spi_pkg

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts shift events within an SPI frame whose length is
// programmed at runtime.
// - listo flags the last bit of the frame.
// - done pulses once the frame completes.
// - err pulses when a start is rejected because the length is zero.
// - All state changes on the FALLING edge of clk, which matches the SPI shift
//   timing.
// - rst is asynchronous and active-low.
// Optional feature, selected by the SPI_BIT_CNT_TALLY_EN macro: adds the
// frames output, a wrapping count of completed frames that only rst clears.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int CNT_W = SPI_CNT_W_DEF,
  parameter int FRM_W = SPI_FRM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             enable,
  input  logic             reload,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cuenta,
  output logic             busy,
  output logic             listo,
  output logic             done,
  output logic             err
`ifdef SPI_BIT_CNT_TALLY_EN
  ,
  output logic [FRM_W-1:0] frames
`endif
);

  // A zero-width counter or tally is meaningless; reject it at elaboration.
  if (CNT_W < 1 || FRM_W < 1) begin : g_param_chk
    $error("spi_bit_counter: CNT_W and FRM_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             in_run;
  logic             last_bit;
  logic [CNT_W-1:0] last_idx;
  logic             frame_end;

  // Locate the last bit of the frame. len_q is never zero while in RUN, so
  // len_q-1 cannot underflow there.
  always_comb begin
    in_run    = (state_q == RUN);
    last_idx  = len_q - CNT_W'(1);
    last_bit  = in_run && (cuenta_q == last_idx);
    frame_end = last_bit && enable && !abort;
  end

  // Next-state, counter and pulse logic.
  // - abort has the highest priority and clears everything, with no done.
  // - start is only sampled in IDLE.
  // - In RUN, enable=0 freezes the count (pause).
  always_comb begin
    state_d  = state_q;
    cuenta_d = cuenta_q;
    len_d    = len_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      cuenta_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_d    = len;
              cuenta_d = '0;
              state_d  = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (last_bit) begin
              done_d   = 1'b1;
              cuenta_d = '0;
              // reload is sampled on the same edge that completes the frame.
              if (!reload) begin
                state_d = IDLE;
              end
            end else begin
              // Cannot wrap: the count stops at len_q-1, which is at most
              // 2**CNT_W-2.
              cuenta_d = cuenta_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit index, latched frame length and the registered done/err pulses.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cuenta_q <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef SPI_BIT_CNT_TALLY_EN
  logic [FRM_W-1:0] frames_q;

  // Completed-frame tally. It wraps modulo 2**FRM_W, aborted frames are not
  // counted, and only rst clears it.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      frames_q <= '0;
    end else if (frame_end) begin
      frames_q <= frames_q + FRM_W'(1);
    end
  end

  assign frames = frames_q;
`endif

  assign cuenta = cuenta_q;
  assign busy   = in_run;
  assign listo  = last_bit;
  assign done   = done_q;
  assign err    = err_q;

endmodule : spi_bit_counter
